// File: rtl/i2c_opl3_reg_bridge_pkg.sv
// Shared definitions for the I2C-to-OPL3 register bridge: parser states,
// entry layout and the bank-byte check mask.
package i2c_opl3_reg_bridge_pkg;

  localparam int OPL_ADDR_W = 9;
  localparam int ENTRY_W    = 17;

  // Only bit 0 of the bank byte may be set; any bit under this mask is a framing error.
  localparam logic [7:0] BANK_BYTE_MASK = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_BANK = 3'd1,
    ST_GET_REG  = 3'd2,
    ST_GET_DATA = 3'd3,
    ST_DISCARD  = 3'd4
  } state_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic       bank,
                                                    input logic [7:0] reg_addr,
                                                    input logic [7:0] data);
    return {bank, reg_addr, data};
  endfunction

endpackage

// File: rtl/opl3_wr_fifo.sv
// Synchronous write buffer with first-word fall-through read port.
// A push while full is only taken when a pop happens in the same cycle.
module opl3_wr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 17
) (
  input  logic                     clk_10MHz,
  input  logic                     areset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; everything clears on reset so no stale entry survives.
  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/i2c_opl3_reg_bridge.sv
// Parses I2C write frames {bank, reg, data...} into OPL3 register writes,
// buffers them and issues them to the synth core no closer than WR_GAP cycles.
module i2c_opl3_reg_bridge #(
  parameter int FIFO_DEPTH = 16,
  parameter int WR_GAP     = 36
) (
  input  logic       clk_10MHz,
  input  logic       areset_n,
  input  logic       rx_start,
  input  logic       rx_stop,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       opl_wr,
  output logic [8:0] opl_addr,
  output logic [7:0] opl_data,
  output logic       err_frame,
  output logic       err_ovf
);
  import i2c_opl3_reg_bridge_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WR_GAP - 1);

  state_t             state_q, state_d;
  logic               bank_q, bank_d;
  logic [7:0]         reg_q, reg_d;
  logic               push;
  logic               pop;
  logic               set_frame_err;
  logic               set_ovf_err;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [GAP_W-1:0]   gap_q;

  opl3_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_10MHz (clk_10MHz),
    .areset_n  (areset_n),
    .push      (push),
    .wr_data   (pack_entry(bank_q, reg_q, rx_data)),
    .pop       (pop),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign pop      = !fifo_empty && (gap_q == '0);

  // Parser state, bank and running register address.
  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
      bank_q  <= 1'b0;
      reg_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      reg_q   <= reg_d;
    end
  end

  // Next-state decode: framing events beat data, and a byte arriving while full changes nothing.
  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    reg_d         = reg_q;
    push          = 1'b0;
    set_frame_err = 1'b0;
    set_ovf_err   = 1'b0;
    if (rx_start) begin
      state_d       = ST_GET_BANK;
      set_frame_err = rx_valid;
    end else if (rx_stop) begin
      state_d       = ST_IDLE;
      set_frame_err = rx_valid;
    end else if (rx_valid) begin
      if (fifo_full) begin
        set_ovf_err = 1'b1;
      end else begin
        case (state_q)
          ST_GET_BANK: begin
            if ((rx_data & BANK_BYTE_MASK) != 8'h00) begin
              set_frame_err = 1'b1;
              state_d       = ST_DISCARD;
            end else begin
              bank_d  = rx_data[0];
              state_d = ST_GET_REG;
            end
          end
          ST_GET_REG: begin
            reg_d   = rx_data;
            state_d = ST_GET_DATA;
          end
          ST_GET_DATA: begin
            push  = 1'b1;
            reg_d = reg_q + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) begin
      err_frame <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (set_frame_err) err_frame <= 1'b1;
      if (set_ovf_err)   err_ovf   <= 1'b1;
    end
  end

  // Drain: issue the popped head as a one-cycle strobe and hold off the next pop for WR_GAP cycles.
  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) begin
      opl_wr   <= 1'b0;
      opl_addr <= '0;
      opl_data <= '0;
      gap_q    <= '0;
    end else begin
      opl_wr <= pop;
      if (pop) begin
        opl_addr <= head[ENTRY_W-1:8];
        opl_data <= head[7:0];
        gap_q    <= GAP_LOAD;
      end else if (gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

endmodule
